// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus: instruction-memory handshake, decoder controls and the instruction view.
// master = fetch unit; slave = memory/decoder side (testbench, datapath).
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall;
    logic        retire;
    logic        branch;
    logic        zero;
    logic [1:0]  jump;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [5:0]  op_field;
    logic [5:0]  funct;
    logic        instr_valid;
    logic        addr_err;
    logic [31:0] instr_count;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_ready, stall, retire, branch, zero, jump, jr_target,
        output pc, pc_plus4, instr, op_field, funct, instr_valid, addr_err, instr_count
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_ready, stall, retire, branch, zero, jump, jr_target,
        input  pc, pc_plus4, instr, op_field, funct, instr_valid, addr_err, instr_count
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// MIPS PC/fetch stage: BOOT -> FETCH (waits on imem_ready, >=1 cycle) -> ISSUE (waits on retire).
// Backpressure: stall freezes ISSUE entirely; imem_addr stays at pc until memory responds.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            reset,
    instr_fetch_unit_if.master bus
);
    typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, ISSUE = 2'd2} state_t;

    state_t      state, stateNext;
    logic [31:0] pc, instr, instrCount;
    logic [31:0] pcPlus4, nextPc, branchOffset;
    logic        instrValid, addrErr;
    logic        captureInstr, doRetire, jrMisaligned;

    assign pcPlus4      = pc + 32'd4;
    assign branchOffset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext    = state;
        bus.imem_req = 1'b0;
        captureInstr = 1'b0;
        doRetire     = 1'b0;
        case (state)
            BOOT:  stateNext = FETCH;
            FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    captureInstr = 1'b1;
                    stateNext    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.retire && !bus.stall) begin
                    doRetire  = 1'b1;
                    stateNext = FETCH;
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    // Jump encodings beat branch; 2'b11 behaves as sequential/branch.
    always_comb begin
        nextPc       = pcPlus4;
        jrMisaligned = 1'b0;
        case (bus.jump)
            2'b01: nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
            2'b10: begin
                nextPc       = {bus.jr_target[31:2], 2'b00};
                jrMisaligned = |bus.jr_target[1:0];
            end
            default: if (bus.branch && bus.zero) nextPc = pcPlus4 + branchOffset;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            instr      <= 32'h0;
            instrValid <= 1'b0;
            addrErr    <= 1'b0;
            instrCount <= 32'h0;
        end else begin
            if (captureInstr) begin
                instr      <= bus.imem_rdata;
                instrValid <= 1'b1;
            end
            if (doRetire) begin
                pc         <= nextPc;
                instrValid <= 1'b0;
                instrCount <= instrCount + 32'd1;
                if (jrMisaligned) addrErr <= 1'b1;
            end
        end
    end

    assign bus.imem_addr   = pc;
    assign bus.pc          = pc;
    assign bus.pc_plus4    = pcPlus4;
    assign bus.instr       = instr;
    assign bus.op_field    = instr[31:26];
    assign bus.funct       = instr[5:0];
    assign bus.instr_valid = instrValid;
    assign bus.addr_err    = addrErr;
    assign bus.instr_count = instrCount;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: vector table, hand-written corner sequences, then random traffic
// checked against an arithmetic next-PC model.
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .reset(reset), .bus(bus));

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] mPc, mCount, mInstr;
    logic        mErr;

    typedef struct {
        logic [31:0] startPc;
        logic [31:0] word;
        logic        b;
        logic        z;
        logic [1:0]  j;
        logic [31:0] jrt;
        logic [31:0] expPc;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] refNext(input logic [31:0] pcv, input logic [31:0] ins,
                                            input logic b, input logic z,
                                            input logic [1:0] j, input logic [31:0] jrt);
        logic [31:0] seq;
        int          off;
        seq = pcv + 32'd4;
        if (j == 2'b01) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 32'd4);
        if (j == 2'b10) return jrt - (jrt % 32'd4);
        if (b && z) begin
            off = int'($signed(ins[15:0])) * 4;
            return seq + 32'(off);
        end
        return seq;
    endfunction

    // Precondition: at a negedge with the DUT in FETCH.
    task automatic fetchWord(input logic [31:0] word, input int delay);
        for (int i = 0; i < delay; i++) begin
            check("fetch_req_wait", 32'(bus.imem_req), 32'd1);
            check("fetch_addr_wait", bus.imem_addr, mPc);
            @(negedge clk);
        end
        check("fetch_req", 32'(bus.imem_req), 32'd1);
        check("fetch_addr", bus.imem_addr, mPc);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
        mInstr = word;
        check("instr_valid_set", 32'(bus.instr_valid), 32'd1);
        check("instr", bus.instr, word);
        check("op_field", 32'(bus.op_field), word >> 26);
        check("funct", 32'(bus.funct), word & 32'h3F);
        check("pc_plus4", bus.pc_plus4, mPc + 32'd4);
        check("issue_req_low", 32'(bus.imem_req), 32'd0);
    endtask

    // Precondition: at a negedge with the DUT in ISSUE.
    task automatic retireOp(input logic b, input logic z, input logic [1:0] j,
                            input logic [31:0] jrt, input int stallCyc, input bit probe);
        if (probe) begin
            bus.imem_ready = 1'b1;
            bus.imem_rdata = ~mInstr;
            @(negedge clk);
            bus.imem_ready = 1'b0;
            check("issue_ignores_ready", bus.instr, mInstr);
            check("issue_pc_hold", bus.pc, mPc);
        end
        bus.retire = 1'b1;
        bus.stall  = (stallCyc > 0);
        for (int i = 0; i < stallCyc; i++) begin
            bus.branch    = 1'($urandom);
            bus.zero      = 1'($urandom);
            bus.jump      = 2'($urandom);
            bus.jr_target = $urandom | 32'h1;
            @(negedge clk);
            check("stall_pc_hold", bus.pc, mPc);
            check("stall_valid_hold", 32'(bus.instr_valid), 32'd1);
            check("stall_count_hold", bus.instr_count, mCount);
            check("stall_err_hold", 32'(bus.addr_err), 32'(mErr));
        end
        bus.stall     = 1'b0;
        bus.branch    = b;
        bus.zero      = z;
        bus.jump      = j;
        bus.jr_target = jrt;
        @(negedge clk);
        bus.retire = 1'b0;
        if (j == 2'b10 && (jrt % 32'd4) != 0) mErr = 1'b1;
        mPc    = refNext(mPc, mInstr, b, z, j, jrt);
        mCount = mCount + 32'd1;
        check("retire_pc", bus.pc, mPc);
        check("retire_addr", bus.imem_addr, mPc);
        check("retire_valid_clr", 32'(bus.instr_valid), 32'd0);
        check("retire_req", 32'(bus.imem_req), 32'd1);
        check("retire_count", bus.instr_count, mCount);
        check("retire_err", 32'(bus.addr_err), 32'(mErr));
    endtask

    task automatic setPc(input logic [31:0] target);
        fetchWord(32'h0, 0);
        retireOp(1'b0, 1'b0, 2'b10, target, 0, 1'b0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0040, 32'h0000_0000, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0044};
        vecs[1] = '{32'h0000_0100, 32'h1000_FFFE, 1'b1, 1'b1, 2'b00, 32'h0,         32'h0000_00FC};
        vecs[2] = '{32'h0000_0100, 32'h1000_FFFE, 1'b1, 1'b0, 2'b00, 32'h0,         32'h0000_0104};
        vecs[3] = '{32'h1000_0000, 32'h0800_0010, 1'b1, 1'b1, 2'b01, 32'h0,         32'h1000_0040};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 2'b00, 32'h0,         32'h0000_0000};
        vecs[5] = '{32'h0000_0200, 32'h1000_0003, 1'b1, 1'b1, 2'b11, 32'h0,         32'h0000_0210};
        vecs[6] = '{32'h0000_0000, 32'h1000_FFF0, 1'b1, 1'b1, 2'b00, 32'h0,         32'hFFFF_FFC4};
        vecs[7] = '{32'h0000_0300, 32'h0000_0000, 1'b1, 1'b1, 2'b10, 32'h0000_1234, 32'h0000_1234};

        reset = 1'b1;
        bus.imem_rdata = 32'h0; bus.imem_ready = 1'b0; bus.stall = 1'b0; bus.retire = 1'b0;
        bus.branch = 1'b0; bus.zero = 1'b0; bus.jump = 2'b00; bus.jr_target = 32'h0;
        mPc = 32'h0; mCount = 32'h0; mErr = 1'b0; mInstr = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_err", 32'(bus.addr_err), 32'd0);
        check("rst_count", bus.instr_count, 32'h0);
        check("rst_req", 32'(bus.imem_req), 32'd0);

        // Boot: one BOOT cycle, then two request cycles before the response lands.
        reset = 1'b0;
        #1 check("boot_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        fetchWord(32'h2008_0005, 1);
        check("boot_op_field", 32'(bus.op_field), 32'h08);
        check("boot_funct", 32'(bus.funct), 32'h05);
        retireOp(1'b0, 1'b0, 2'b00, 32'h0, 0, 1'b0);
        check("first_count", bus.instr_count, 32'd1);

        for (int k = 0; k < 8; k++) begin
            setPc(vecs[k].startPc);
            check("vec_fetch_addr", bus.imem_addr, vecs[k].startPc);
            fetchWord(vecs[k].word, k % 3);
            retireOp(vecs[k].b, vecs[k].z, vecs[k].j, vecs[k].jrt, 0, 1'(k % 2));
            check("vec_next_pc", bus.pc, vecs[k].expPc);
        end

        // Misaligned jr held under stall; the error flag must then stay set.
        setPc(32'h0000_0500);
        fetchWord(32'h03E0_0008, 0);
        retireOp(1'b0, 1'b0, 2'b10, 32'h0000_0203, 3, 1'b0);
        check("jr_pc", bus.pc, 32'h0000_0200);
        check("jr_err", 32'(bus.addr_err), 32'd1);
        fetchWord(32'h0000_0000, 1);
        retireOp(1'b0, 1'b0, 2'b00, 32'h0, 0, 1'b0);
        check("err_sticky", 32'(bus.addr_err), 32'd1);

        // Asynchronous reset while fetching at 0x80, with a response arriving under reset.
        setPc(32'h0000_0080);
        @(negedge clk);
        check("mid_fetch_addr", bus.imem_addr, 32'h0000_0080);
        #2 reset = 1'b1;
        #1;
        check("async_pc", bus.pc, 32'h0);
        check("async_valid", 32'(bus.instr_valid), 32'd0);
        check("async_req", 32'(bus.imem_req), 32'd0);
        check("async_count", bus.instr_count, 32'h0);
        check("async_err", 32'(bus.addr_err), 32'd0);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        check("late_resp_instr", bus.instr, 32'h0);
        check("late_resp_valid", 32'(bus.instr_valid), 32'd0);
        reset = 1'b0;
        mPc = 32'h0; mCount = 32'h0; mErr = 1'b0;
        #1 check("reboot_req_low", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        check("reboot_addr", bus.imem_addr, 32'h0);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] word, jrt;
            logic [1:0]  j;
            word = $urandom;
            jrt  = $urandom;
            if ($urandom_range(0, 3) != 0) jrt = jrt & 32'hFFFF_FFFC;
            j = 2'($urandom_range(0, 3));
            fetchWord(word, $urandom_range(0, 3));
            retireOp(1'($urandom), 1'($urandom), j, jrt, $urandom_range(0, 2), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
